decode_queue_ctrl: RTL

- Sequences instruction delivery into the combinational RV64 instruction decoder.
- Buffers fetched instructions in a small FIFO and presents the head entry's raw instruction to the decoder.
- Issues decoded entries to execute over a valid/ready handshake, holding on load-use hazards and discarding all state on pipeline flush.
- Sits between the fetch stage and the ID/EX pipeline register.

---
 rtl/decode_queue_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/decode_queue_ctrl.sv
// Instruction queue in front of the combinational RV64 decoder: buffers fetched
// {instr, pc}, checks load-use hazards on the head and issues to ID/EX. Option: DECODE_ILLEGAL_TRAP_EN.
module decode_queue_ctrl #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [31:0]              if_instr,
    input  logic [XLEN-1:0]          if_pc,
    input  logic                     flush,
    output logic [31:0]              dec_instr,
    input  logic [2:0]               dec_format,
    input  logic [4:0]               dec_rs1,
    input  logic [4:0]               dec_rs2,
    input  logic                     ex_is_load,
    input  logic [4:0]               ex_rd,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_pc,
    output logic                     id_illegal,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   stall_q, stall_d;

    logic not_empty, push, pop, hazard, invalid_fmt, issuable, drop;
    logic rs1_used, rs2_used;

    always_comb begin
        not_empty   = (count_q != '0);
        if_ready    = (count_q != FULL_CNT) & ~rst;
        push        = if_valid & if_ready & ~flush;

        dec_instr   = not_empty ? instr_mem[rd_ptr_q] : NOP;
        id_pc       = not_empty ? pc_mem[rd_ptr_q] : '0;

        rs1_used    = (dec_format <= 3'd3);
        rs2_used    = (dec_format == 3'd0) | (dec_format == 3'd2) | (dec_format == 3'd3);
        invalid_fmt = (dec_format == 3'd7);
        hazard      = ex_is_load & (ex_rd != 5'd0) &
                      ((rs1_used & (dec_rs1 == ex_rd)) | (rs2_used & (dec_rs2 == ex_rd)));

`ifdef DECODE_ILLEGAL_TRAP_EN
        // Illegal head travels down the pipe so execute can raise the exception.
        issuable    = 1'b1;
        drop        = 1'b0;
        id_illegal  = not_empty & invalid_fmt;
`else
        // Illegal head is silently discarded without ever being offered.
        issuable    = ~invalid_fmt;
        drop        = not_empty & invalid_fmt & ~flush;
        id_illegal  = 1'b0;
`endif

        id_valid    = not_empty & ~hazard & ~flush & issuable;
        pop         = (id_valid & id_ready) | drop;

        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        stall_d     = stall_q;
        if (not_empty & hazard & ~flush & (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end

        occupancy   = count_q;
        stall_cnt   = stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            stall_q <= stall_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
            end
        end
    end

    // Storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= if_instr;
            pc_mem[wr_ptr_q]    <= if_pc;
        end
    end

endmodule
